// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA raster engine.
//   vga_phase_e : where a counter sits within its axis (active, front porch,
//                 sync, back porch).
//   in_window   : half-open range test lo <= cnt < hi.
//   BAR_COUNT   : number of vertical bars in the built-in test pattern.
package vga_pkg;

  localparam int BAR_COUNT = 8;

  typedef enum logic [1:0] {
    ACTIVE,
    FPORCH,
    SYNC,
    BPORCH
  } vga_phase_e;

  function automatic logic in_window(input int cnt, input int lo, input int hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical): a counter running over
// ACTIVE+FP+SYNC+BP positions, advancing whenever step is high.
// Ports:
//   clk_in, rst_n : clock, synchronous active-low reset
//   step          : advance the count by one position
//   cnt           : current position, 0 .. total-1
//   wrap          : high when this step returns the count to 0
//   sync          : sync level for the current position (POL when asserted)
//   phase         : which region of the axis cnt is in
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = 1'b0,
  parameter int   CNT_W  = 12
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync,
  output vga_phase_e       phase
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  assign wrap = step && (cnt == LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  // The enum literals share names with the parameters, so they are qualified.
  always_comb begin
    phase = vga_pkg::BPORCH;
    if (in_window(int'(cnt), 0, ACTIVE))
      phase = vga_pkg::ACTIVE;
    else if (in_window(int'(cnt), ACTIVE, ACTIVE + FP))
      phase = vga_pkg::FPORCH;
    else if (in_window(int'(cnt), ACTIVE + FP, ACTIVE + FP + SYNC))
      phase = vga_pkg::SYNC;
  end

  assign sync = (phase == vga_pkg::SYNC) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine. A pixel tick every PIX_DIV clk_in cycles
// (while en is high) advances the x/y raster; framebuffer reads are issued
// for visible pixels, and syncs, RGB and the line/frame pulses reach the pins
// through two tick-wide pipeline stages, so all outputs are mutually aligned.
// Build option: define VGA_TEST_PATTERN_EN to replace framebuffer data with
// eight vertical colour bars (fb_rd is then held low and fb_data ignored).
// Ports:
//   clk_in, rst_n : system clock, synchronous active-low reset
//   en            : run enable; low freezes the raster and all outputs
//   fb_rd         : one-cycle framebuffer read strobe for (fb_x, fb_y)
//   fb_x, fb_y    : read coordinates
//   fb_data       : {r,g,b}, sampled on the pixel tick following fb_rd
//   hSync, vSync  : syncs, asserted at H_POL / V_POL
//   red/green/blue: pixel colour, forced to 0 outside the visible area
//   line_start    : one-cycle pulse aligned with pixel x=0 on the pins
//   frame_start   : one-cycle pulse aligned with pixel (0,0) on the pins
//   frame_cnt     : completed frames, wrapping at 2^16
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   COLOR_W  = 3,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   PIX_DIV  = 2,
  parameter int   CNT_W    = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 fb_rd,
  output logic [CNT_W-1:0]     fb_x,
  output logic [CNT_W-1:0]     fb_y,
  input  logic [3*COLOR_W-1:0] fb_data,
  output logic                 hSync,
  output logic                 vSync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [15:0]          frame_cnt
);

  // Packed so that fb_data maps onto it directly as {r,g,b}.
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             tick;

  // With PIX_DIV=1 div stays 0 and every enabled cycle is a tick.
  assign tick = en && (div == DIV_W'(PIX_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      div <= '0;
    end else if (en) begin
      div <= tick ? '0 : div + DIV_W'(1);
    end
  end

  logic [CNT_W-1:0] x, y;
  logic             h_wrap, v_wrap, h_sync, v_sync;
  vga_phase_e       h_phase, v_phase;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk_in(clk_in), .rst_n(rst_n), .step(tick),
    .cnt(x), .wrap(h_wrap), .sync(h_sync), .phase(h_phase)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk_in(clk_in), .rst_n(rst_n), .step(h_wrap),
    .cnt(y), .wrap(v_wrap), .sync(v_sync), .phase(v_phase)
  );

  // ---- stage 0: decode of the live counter state ----
  logic vld_p0, ls_p0, fs_p0;

  assign vld_p0 = (h_phase == ACTIVE) && (v_phase == ACTIVE);
  assign ls_p0  = (x == '0);
  assign fs_p0  = ls_p0 && (y == '0);

  // v_wrap already implies a tick on the last pixel of the frame.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      fb_x <= '0;
      fb_y <= '0;
    end else if (tick) begin
      fb_x <= x;
      fb_y <= y;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  assign fb_rd = 1'b0;

  // bar = (x*8)/H_ACTIVE: count how many of the seven bar edges x*8 has passed.
  function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] xv);
    logic [2:0] b;
    b = 3'd0;
    for (int k = 1; k < BAR_COUNT; k++) begin
      if ({xv, 3'b000} >= (CNT_W + 3)'(k * H_ACTIVE)) b = 3'(k);
    end
    return b;
  endfunction

  function automatic rgb_t bar_rgb(input logic [2:0] bar);
    rgb_t c;
    c.r = {COLOR_W{bar[2]}};
    c.g = {COLOR_W{bar[1]}};
    c.b = {COLOR_W{bar[0]}};
    return c;
  endfunction
`else
  always_ff @(posedge clk_in) begin
    if (!rst_n) fb_rd <= 1'b0;
    else        fb_rd <= tick && vld_p0;
  end
`endif

  // ---- stage 1: decoded raster state, one tick behind the counters ----
  logic vld_p1, hs_p1, vs_p1, ls_p1, fs_p1;
  rgb_t pix_p1;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      hs_p1  <= ~H_POL;
      vs_p1  <= ~V_POL;
      ls_p1  <= 1'b0;
      fs_p1  <= 1'b0;
    end else if (tick) begin
      vld_p1 <= vld_p0;
      hs_p1  <= h_sync;
      vs_p1  <= v_sync;
      ls_p1  <= ls_p0;
      fs_p1  <= fs_p0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  rgb_t bar_p1;

  always_ff @(posedge clk_in) begin
    if (tick) bar_p1 <= bar_rgb(bar_index(x));
  end

  assign pix_p1 = bar_p1;
`else
  // The read issued at the previous tick has its data ready by this tick.
  assign pix_p1 = rgb_t'(fb_data);
`endif

  // ---- stage 2: output registers ----
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      hSync       <= ~H_POL;
      vSync       <= ~V_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulses last one clk_in cycle even though a pixel spans PIX_DIV cycles.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        hSync       <= hs_p1;
        vSync       <= vs_p1;
        line_start  <= ls_p1;
        frame_start <= fs_p1;
        red         <= vld_p1 ? pix_p1.r : '0;
        green       <= vld_p1 ? pix_p1.g : '0;
        blue        <= vld_p1 ? pix_p1.b : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny raster: H 8/2/3/3 (16 pixels),
// V 4/1/2/1 (8 lines), PIX_DIV=2, so one frame is 256 clk_in cycles.
// k counts enabled clk_in edges since reset release; pixel ticks land on
// even k. After edge k the pins show pixel k/2-2 and fb_x/fb_y hold pixel
// k/2-1. fb_data is wired to {fb_x[2:0], fb_y[2:0], 3'b101}.
module tb_vga_timing_gen;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic        fb_rd;
  logic [11:0] fb_x, fb_y;
  logic [8:0]  fb_data;
  logic        hSync, vSync;
  logic [2:0]  red, green, blue;
  logic        line_start, frame_start;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cur_k = 0;
  int hs_low = 0;
  int vs_low = 0;

  always #5 clk_in = ~clk_in;

  assign fb_data = {fb_x[2:0], fb_y[2:0], 3'b101};

  vga_timing_gen #(
    .COLOR_W(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(2), .CNT_W(12)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en),
    .fb_rd(fb_rd), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .hSync(hSync), .vSync(vSync), .red(red), .green(green), .blue(blue),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", tag, cur_k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Expected pins after enabled edge k; frozen suppresses the one-cycle strobes.
  task automatic check_model(input int k, input bit frozen);
    int m, p, q, px, py, qx, qy;
    int e_hs, e_vs, e_ls, e_fs, e_rd, e_r, e_g, e_b;
    bit act;
    m  = k / 2;
    p  = m - 2;
    q  = m - 1;
    px = (p >= 0) ? p % 16 : 0;
    py = (p >= 0) ? (p / 16) % 8 : 0;
    qx = (q >= 0) ? q % 16 : 0;
    qy = (q >= 0) ? (q / 16) % 8 : 0;
    e_hs = (p >= 0 && px >= 10 && px < 13) ? 0 : 1;
    e_vs = (p >= 0 && py >= 5 && py < 7) ? 0 : 1;
    e_ls = (!frozen && p >= 0 && k % 2 == 0 && px == 0) ? 1 : 0;
    e_fs = (e_ls == 1 && py == 0) ? 1 : 0;
    act  = (p >= 0 && px < 8 && py < 4);
`ifdef VGA_TEST_PATTERN_EN
    e_r  = (act && px[2]) ? 7 : 0;
    e_g  = (act && px[1]) ? 7 : 0;
    e_b  = (act && px[0]) ? 7 : 0;
    e_rd = 0;
`else
    e_r  = act ? px % 8 : 0;
    e_g  = act ? py % 8 : 0;
    e_b  = act ? 5 : 0;
    e_rd = (!frozen && q >= 0 && k % 2 == 0 && qx < 8 && qy < 4) ? 1 : 0;
`endif
    cur_k = k;
    chk("hSync", int'(hSync), e_hs);
    chk("vSync", int'(vSync), e_vs);
    chk("line_start", int'(line_start), e_ls);
    chk("frame_start", int'(frame_start), e_fs);
    chk("red", int'(red), e_r);
    chk("green", int'(green), e_g);
    chk("blue", int'(blue), e_b);
    chk("fb_rd", int'(fb_rd), e_rd);
    chk("fb_x", int'(fb_x), qx);
    chk("fb_y", int'(fb_y), qy);
    chk("frame_cnt", int'(frame_cnt), m / 128);
  endtask

  task automatic check_reset_state(input string tag);
    cur_k = 0;
    chk({tag, "_hSync"}, int'(hSync), 1);
    chk({tag, "_vSync"}, int'(vSync), 1);
    chk({tag, "_rgb"}, int'({red, green, blue}), 0);
    chk({tag, "_fb_rd"}, int'(fb_rd), 0);
    chk({tag, "_ls"}, int'(line_start), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  // Colour bars for x = 0..7 as {r,g,b}, each channel 0 or 7.
  logic [8:0] bars [8] = '{9'o000, 9'o007, 9'o070, 9'o077,
                           9'o700, 9'o707, 9'o770, 9'o777};

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (5) step();
    check_reset_state("rst");
    rst_n = 1'b1;

    // Start-up, free run over three frames, read/RGB alignment.
    for (int k = 1; k <= 800; k++) begin
      step();
      check_model(k, 1'b0);
      if (k >= 101 && k <= 132 && hSync == 1'b0) hs_low++;
      if (k >= 5 && k <= 260 && vSync == 1'b0) vs_low++;
      if (k == 3) chk("fs_before_first", int'(frame_start), 0);
      if (k == 4) chk("fs_first", int'(frame_start), 1);
      if (k == 5) chk("fs_one_cycle", int'(frame_start), 0);
`ifdef VGA_TEST_PATTERN_EN
      if (k >= 4 && k <= 18 && k % 2 == 0)
        chk("bar", int'({red, green, blue}), int'(bars[k / 2 - 2]));
`else
      if (k == 76) begin
        chk("rd_5_2", int'(fb_rd), 1);
        chk("rd_5_2_x", int'(fb_x), 5);
        chk("rd_5_2_y", int'(fb_y), 2);
      end
      if (k == 78) chk("rgb_5_2", int'({red, green, blue}), int'({3'd5, 3'd2, 3'd5}));
`endif
      if (k == 767) chk("frame_cnt_767", int'(frame_cnt), 2);
      if (k == 768) chk("frame_cnt_768", int'(frame_cnt), 3);
    end
    chk("hs_low_per_line", hs_low, 6);
    chk("vs_low_per_frame", vs_low, 64);

    // Freeze mid-line, just after the read for (x=4, y=1).
    for (int k = 801; k <= 810; k++) begin
      step();
      check_model(k, 1'b0);
    end
`ifndef VGA_TEST_PATTERN_EN
    chk("rd_before_freeze", int'(fb_rd), 1);
`endif
    chk("fb_x_before_freeze", int'(fb_x), 4);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_model(810, 1'b1);
    end
    en = 1'b1;
    for (int k = 811; k <= 2218; k++) begin
      step();
      check_model(k, 1'b0);
      if (k == 812) chk("resume_x", int'(fb_x), 5);
    end

    // One-cycle reset while vSync is asserted.
    chk("vs_before_rst", int'(vSync), 0);
    rst_n = 1'b0;
    step();
    check_reset_state("midrst");
    chk("midrst_fb_x", int'(fb_x), 0);
    chk("midrst_fb_y", int'(fb_y), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      check_model(k, 1'b0);
      if (k == 4) chk("fs_after_rst", int'(frame_start), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
